// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, requester ids and reset grant.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } arb_state_e;

  typedef enum logic {
    ReqIf = 1'b0,
    ReqD  = 1'b1
  } req_id_e;

  // Starting with IF as "last granted" lets data win the first tie.
  localparam req_id_e LastGrantRst = ReqIf;

endpackage

// File: rtl/mem_arb_timer.sv
// Saturating BUSY-cycle counter; expired_o flags the final allowed wait cycle.
module mem_arb_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CntMax);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch and load/store,
// one transaction at a time, with a ready watchdog and requester stall outputs.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  output logic              if_stall_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ack_o,
  output logic              d_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i,
  output logic              err_o
);

  arb_state_e        state_q;
  req_id_e           gnt_q, last_q, gnt_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              mem_req_q;
  logic              if_ack_q;
  logic              d_ack_q;
  logic              err_q;
  logic              expired;
  logic              any_req;

  assign any_req = if_req_i | d_req_i;

  always_comb begin
    gnt_d = ReqD;
    if (if_req_i && d_req_i) begin
      gnt_d = (last_q == ReqIf) ? ReqD : ReqIf;
    end else if (if_req_i) begin
      gnt_d = ReqIf;
    end
  end

  // Counter sits at zero in IDLE so every access starts with a full budget.
  mem_arb_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (state_q == StIdle),
    .en_i     ((state_q == StBusy) && !mem_ready_i),
    .expired_o(expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      gnt_q     <= ReqIf;
      last_q    <= LastGrantRst;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      mem_req_q <= 1'b0;
      if_ack_q  <= 1'b0;
      d_ack_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (any_req) begin
            gnt_q     <= gnt_d;
            last_q    <= gnt_d;
            addr_q    <= (gnt_d == ReqD) ? d_addr_i : if_addr_i;
            we_q      <= (gnt_d == ReqD) && d_we_i;
            wdata_q   <= (gnt_d == ReqD) ? d_wdata_i : '0;
            mem_req_q <= 1'b1;
            state_q   <= StBusy;
          end
        end
        StBusy: begin
          // Ready wins over an expiring watchdog in the same cycle.
          if (mem_ready_i || expired) begin
            rdata_q   <= (mem_ready_i && !we_q) ? mem_rdata_i : '0;
            err_q     <= !mem_ready_i;
            mem_req_q <= 1'b0;
            if_ack_q  <= (gnt_q == ReqIf);
            d_ack_q   <= (gnt_q == ReqD);
            state_q   <= StResp;
          end
        end
        StResp: begin
          if_ack_q <= 1'b0;
          d_ack_q  <= 1'b0;
          err_q    <= 1'b0;
          state_q  <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_req_q & we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign if_ack_o    = if_ack_q;
  assign d_ack_o     = d_ack_q;
  assign err_o       = err_q;
  assign if_rdata_o  = if_ack_q ? rdata_q : '0;
  assign d_rdata_o   = d_ack_q ? rdata_q : '0;
  assign if_stall_o  = if_req_i & ~if_ack_q;
  assign d_stall_o   = d_req_i & ~d_ack_q;

endmodule
